// File: rtl/rf_scoreboard_arbiter.sv
// rtl/rf_scoreboard_arbiter.sv - register scoreboard with RAW/WAW issue stall and round-robin RF write-port arbiter
module rf_scoreboard_arbiter #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int STALL_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [ADDR_W-1:0] iss_rs1,
  input  logic [ADDR_W-1:0] iss_rs2,
  input  logic [ADDR_W-1:0] iss_dest,
  input  logic              iss_dest_en,
  input  logic              wb_a_valid,
  output logic              wb_a_ready,
  input  logic [ADDR_W-1:0] wb_a_addr,
  input  logic [DATA_W-1:0] wb_a_data,
  input  logic              wb_b_valid,
  output logic              wb_b_ready,
  input  logic [ADDR_W-1:0] wb_b_addr,
  input  logic [DATA_W-1:0] wb_b_data,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_val,
  output logic [ADDR_W:0]   pend_count,
  output logic [STALL_W-1:0] stall_cnt,
  output logic              err_spurious
);

  localparam logic [ADDR_W:0]    CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);
  localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] pend_next;
  logic                last_grant_b;
  logic                grant_a;
  logic                grant_b;
  logic                reserve;
  logic                release_en;
  logic                spurious;
  logic [ADDR_W-1:0]   release_addr;

  // Issue readiness looks only at registered pend bits, so a release is seen one cycle later.
  always_comb begin
    iss_ready = !reset && !pend[iss_rs1] && !pend[iss_rs2] &&
                !(iss_dest_en && pend[iss_dest]);
  end

  // Contention goes to whichever side did not win last; a lone requester always wins.
  always_comb begin
    grant_a = !reset && wb_a_valid && (!wb_b_valid || last_grant_b);
    grant_b = !reset && wb_b_valid && (!wb_a_valid || !last_grant_b);
  end

  always_comb begin
    wb_a_ready    = grant_a;
    wb_b_ready    = grant_b;
    rf_write_en   = grant_a || grant_b;
    rf_write_addr = '0;
    rf_write_val  = '0;
    if (grant_a) begin
      rf_write_addr = wb_a_addr;
      rf_write_val  = wb_a_data;
    end else if (grant_b) begin
      rf_write_addr = wb_b_addr;
      rf_write_val  = wb_b_data;
    end
  end

  always_comb begin
    reserve      = iss_valid && iss_ready && iss_dest_en;
    release_en   = rf_write_en;
    release_addr = rf_write_addr;
    spurious     = release_en && !pend[release_addr];
  end

  // Clear before set: a spurious release racing a reserve of the same register leaves it pending.
  always_comb begin
    pend_next = pend;
    if (release_en) begin
      pend_next[release_addr] = 1'b0;
    end
    if (reserve) begin
      pend_next[iss_dest] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend         <= '0;
      last_grant_b <= 1'b1;
    end else begin
      pend <= pend_next;
      if (grant_a || grant_b) begin
        last_grant_b <= grant_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_count <= '0;
    end else begin
      case ({reserve, release_en && !spurious})
        2'b10:   pend_count <= pend_count + CNT_ONE;
        2'b01:   pend_count <= pend_count - CNT_ONE;
        default: pend_count <= pend_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt    <= '0;
      err_spurious <= 1'b0;
    end else begin
      if (iss_valid && !iss_ready && stall_cnt != STALL_MAX) begin
        stall_cnt <= stall_cnt + STALL_ONE;
      end
      if (spurious) begin
        err_spurious <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_scoreboard_arbiter.sv
// tb/tb_rf_scoreboard_arbiter.sv - directed table plus randomized model check of rf_scoreboard_arbiter
module tb_rf_scoreboard_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        iss_valid, iss_ready, iss_dest_en;
  logic [4:0]  iss_rs1, iss_rs2, iss_dest;
  logic        wb_a_valid, wb_a_ready, wb_b_valid, wb_b_ready;
  logic [4:0]  wb_a_addr, wb_b_addr;
  logic [31:0] wb_a_data, wb_b_data;
  logic        rf_write_en;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_val;
  logic [5:0]  pend_count;
  logic [15:0] stall_cnt;
  logic        err_spurious;

  always #5 clk = ~clk;

  rf_scoreboard_arbiter dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_dest(iss_dest), .iss_dest_en(iss_dest_en),
    .wb_a_valid(wb_a_valid), .wb_a_ready(wb_a_ready), .wb_a_addr(wb_a_addr), .wb_a_data(wb_a_data),
    .wb_b_valid(wb_b_valid), .wb_b_ready(wb_b_ready), .wb_b_addr(wb_b_addr), .wb_b_data(wb_b_data),
    .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_val(rf_write_val),
    .pend_count(pend_count), .stall_cnt(stall_cnt), .err_spurious(err_spurious)
  );

  typedef struct {
    logic rst; logic iv; logic [4:0] rs1; logic [4:0] rs2; logic [4:0] dest; logic den;
    logic av; logic [4:0] aa; logic [31:0] ad; logic bv; logic [4:0] ba; logic [31:0] bd;
    logic chk; logic e_rdy; logic e_ar; logic e_br; logic e_wen; logic [4:0] e_waddr;
    logic [31:0] e_wval; logic [5:0] e_pc; logic e_err;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: the set of pending registers, who won last, and the sticky/saturating counters.
  bit [31:0] m_pend;
  bit        m_last_b;
  int        m_stall;
  bit        m_err;

  function automatic vec_t v(input logic rst, iv, input logic [4:0] rs1, rs2, dest, input logic den,
                             input logic av, input logic [4:0] aa, input logic [31:0] ad,
                             input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                             input logic rdy, ar, br, wen, input logic [4:0] waddr,
                             input logic [31:0] wval, input logic [5:0] pc, input logic err);
    vec_t t;
    t.rst = rst; t.iv = iv; t.rs1 = rs1; t.rs2 = rs2; t.dest = dest; t.den = den;
    t.av = av; t.aa = aa; t.ad = ad; t.bv = bv; t.ba = ba; t.bd = bd;
    t.chk = 1'b1; t.e_rdy = rdy; t.e_ar = ar; t.e_br = br; t.e_wen = wen;
    t.e_waddr = waddr; t.e_wval = wval; t.e_pc = pc; t.e_err = err;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run(input vec_t t, output bit ga, output bit gb);
    bit rdy;
    logic [4:0] w;
    @(negedge clk);
    reset = t.rst; iss_valid = t.iv; iss_rs1 = t.rs1; iss_rs2 = t.rs2;
    iss_dest = t.dest; iss_dest_en = t.den;
    wb_a_valid = t.av; wb_a_addr = t.aa; wb_a_data = t.ad;
    wb_b_valid = t.bv; wb_b_addr = t.ba; wb_b_data = t.bd;
    #1;
    rdy = !t.rst && !m_pend[t.rs1] && !m_pend[t.rs2] && !(t.den && m_pend[t.dest]);
    ga  = !t.rst && t.av && (!t.bv || m_last_b);
    gb  = !t.rst && t.bv && (!t.av || !m_last_b);
    w   = ga ? t.aa : t.ba;
    check("iss_ready", 32'(iss_ready), 32'(rdy));
    check("wb_a_ready", 32'(wb_a_ready), 32'(ga));
    check("wb_b_ready", 32'(wb_b_ready), 32'(gb));
    check("rf_write_en", 32'(rf_write_en), 32'(ga || gb));
    if (ga || gb) begin
      check("rf_write_addr", 32'(rf_write_addr), 32'(w));
      check("rf_write_val", rf_write_val, ga ? t.ad : t.bd);
    end
    if (t.chk) begin
      check("tbl_iss_ready", 32'(iss_ready), 32'(t.e_rdy));
      check("tbl_a_ready", 32'(wb_a_ready), 32'(t.e_ar));
      check("tbl_b_ready", 32'(wb_b_ready), 32'(t.e_br));
      check("tbl_write_en", 32'(rf_write_en), 32'(t.e_wen));
      if (t.e_wen) begin
        check("tbl_write_addr", 32'(rf_write_addr), 32'(t.e_waddr));
        check("tbl_write_val", rf_write_val, t.e_wval);
      end
    end
    @(posedge clk);
    if (t.rst) begin
      m_pend = '0; m_last_b = 1'b1; m_stall = 0; m_err = 1'b0;
    end else begin
      if (ga || gb) begin
        if (!m_pend[w]) m_err = 1'b1;
        m_pend[w] = 1'b0;
        m_last_b = gb;
      end
      if (t.iv && rdy && t.den) m_pend[t.dest] = 1'b1;
      if (t.iv && !rdy && m_stall < 65535) m_stall++;
    end
    #1;
    check("pend_count", 32'(pend_count), 32'($countones(m_pend)));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    check("err_spurious", 32'(err_spurious), 32'(m_err));
    if (t.chk) begin
      check("tbl_pend_count", 32'(pend_count), 32'(t.e_pc));
      check("tbl_err", 32'(err_spurious), 32'(t.e_err));
    end
  endtask

  vec_t tbl[$];
  vec_t rv;
  bit   ga, gb;

  initial begin
    reset = 1'b1; iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_dest = 0; iss_dest_en = 0;
    wb_a_valid = 0; wb_a_addr = 0; wb_a_data = 0; wb_b_valid = 0; wb_b_addr = 0; wb_b_data = 0;
    m_pend = '0; m_last_b = 1'b1; m_stall = 0; m_err = 1'b0;

    tbl.push_back(v(1,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0, 0,0));
    tbl.push_back(v(1,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0, 0,0));
    tbl.push_back(v(0,1,1,2,3,1, 0,0,0, 0,0,0, 1,0,0,0,0,0, 1,0));
    tbl.push_back(v(0,1,3,0,9,1, 1,3,32'h55, 0,0,0, 0,1,0,1,3,32'h55, 0,0));
    tbl.push_back(v(0,1,3,0,9,0, 0,0,0, 0,0,0, 1,0,0,0,0,0, 0,0));
    tbl.push_back(v(1,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0, 0,0));
    tbl.push_back(v(0,1,0,0,4,1, 0,0,0, 0,0,0, 1,0,0,0,0,0, 1,0));
    tbl.push_back(v(0,1,0,0,5,1, 0,0,0, 0,0,0, 1,0,0,0,0,0, 2,0));
    tbl.push_back(v(0,0,0,0,0,0, 1,4,32'h44, 1,5,32'h55, 1,1,0,1,4,32'h44, 1,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0, 1,5,32'h55, 1,0,1,1,5,32'h55, 0,0));
    tbl.push_back(v(0,1,0,0,4,1, 0,0,0, 0,0,0, 1,0,0,0,0,0, 1,0));
    tbl.push_back(v(0,1,0,0,5,1, 0,0,0, 0,0,0, 1,0,0,0,0,0, 2,0));
    tbl.push_back(v(0,1,0,0,8,1, 0,0,0, 0,0,0, 1,0,0,0,0,0, 3,0));
    tbl.push_back(v(0,0,0,0,0,0, 1,8,32'h88, 0,0,0, 1,1,0,1,8,32'h88, 2,0));
    tbl.push_back(v(0,0,0,0,0,0, 1,4,32'h44, 1,5,32'h5b, 1,0,1,1,5,32'h5b, 1,0));
    tbl.push_back(v(0,0,0,0,0,0, 1,4,32'h44, 0,0,0, 1,1,0,1,4,32'h44, 0,0));
    tbl.push_back(v(0,1,0,0,6,1, 0,0,0, 0,0,0, 1,0,0,0,0,0, 1,0));
    tbl.push_back(v(0,1,0,0,6,1, 0,0,0, 0,0,0, 0,0,0,0,0,0, 1,0));
    tbl.push_back(v(0,1,1,2,6,0, 0,0,0, 0,0,0, 1,0,0,0,0,0, 1,0));
    tbl.push_back(v(0,0,0,0,0,0, 1,6,32'h66, 0,0,0, 1,1,0,1,6,32'h66, 0,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0, 1,7,32'hdead, 1,0,1,1,7,32'hdead, 0,1));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0, 0,0,0, 1,0,0,0,0,0, 0,1));
    tbl.push_back(v(0,1,0,0,1,1, 0,0,0, 0,0,0, 1,0,0,0,0,0, 1,1));
    tbl.push_back(v(0,1,0,0,2,1, 0,0,0, 0,0,0, 1,0,0,0,0,0, 2,1));
    tbl.push_back(v(0,1,0,0,3,1, 0,0,0, 0,0,0, 1,0,0,0,0,0, 3,1));
    tbl.push_back(v(1,1,0,0,9,1, 1,1,32'h11, 0,0,0, 0,0,0,0,0,0, 0,0));
    tbl.push_back(v(0,1,1,2,3,1, 0,0,0, 0,0,0, 1,0,0,0,0,0, 1,0));

    foreach (tbl[i]) run(tbl[i], ga, gb);

    // A losing writeback keeps presenting the same request until it is granted.
    rv = v(0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0, 0,0);
    rv.chk = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rv.rst  = ($urandom_range(0, 199) == 0);
      rv.iv   = $urandom_range(0, 1);
      rv.rs1  = 5'($urandom_range(0, 7));
      rv.rs2  = 5'($urandom_range(0, 7));
      rv.dest = 5'($urandom_range(0, 7));
      rv.den  = ($urandom_range(0, 3) != 0);
      if (!rv.av) begin
        rv.av = $urandom_range(0, 1);
        rv.aa = 5'($urandom_range(0, 7));
        for (int k = 0; k < 8 && $urandom_range(0, 7) != 0; k++)
          if (!m_pend[rv.aa]) rv.aa = 5'((rv.aa + 1) % 8);
        rv.ad = $urandom;
      end
      if (!rv.bv) begin
        rv.bv = $urandom_range(0, 1);
        rv.ba = 5'($urandom_range(0, 7));
        for (int k = 0; k < 8 && $urandom_range(0, 7) != 0; k++)
          if (!m_pend[rv.ba]) rv.ba = 5'((rv.ba + 3) % 8);
        rv.bd = $urandom;
      end
      run(rv, ga, gb);
      if (ga || rv.rst) rv.av = 1'b0;
      if (gb || rv.rst) rv.bv = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
